// File: rtl/ff_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : ff_param_loader
// Description : Receives the feed-forward network parameter stream, decodes
//               each word into flat address and layer/neuron/input indices,
//               and drives a registered weight/bias write port.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_param_loader #(
    parameter int DATA_W = 32,
    parameter int SIZE_W = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SIZE_W-1:0] first_layer,
    input  logic [SIZE_W-1:0] second_layer,
    input  logic [SIZE_W-1:0] third_layer,
    input  logic [SIZE_W-1:0] fourth_layer,
    input  logic [DATA_W-1:0] data,
    input  logic              in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_layer,
    output logic              wr_is_bias,
    output logic [SIZE_W-1:0] wr_neuron,
    output logic [SIZE_W-1:0] wr_input,
    output logic              busy,
    output logic              loaded,
    output logic              err,
    output logic              overrun
);

    localparam int PW = 2 * SIZE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state;
    logic [SIZE_W-1:0] n0, n1, n2, n3;
    logic [1:0]        t;
    logic              phase;
    logic [SIZE_W-1:0] j, i;
    logic [ADDR_W-1:0] addr;

    logic [SIZE_W-1:0] n_in, n_out;
    logic [PW-1:0]     p01, p12, p23;
    logic [ADDR_W-1:0] total;
    logic              any_zero;
    logic              last_word;

    assign any_zero = (first_layer == '0) || (second_layer == '0) ||
                      (third_layer == '0) || (fourth_layer == '0);

    // Sizes of the layers on either side of the current transition
    assign n_in  = (t == 2'd0) ? n0 : (t == 2'd1) ? n1 : n2;
    assign n_out = (t == 2'd0) ? n1 : (t == 2'd1) ? n2 : n3;

    assign p01   = PW'(n0) * PW'(n1);
    assign p12   = PW'(n1) * PW'(n2);
    assign p23   = PW'(n2) * PW'(n3);
    assign total = ADDR_W'(p01) + ADDR_W'(n1) + ADDR_W'(p12) + ADDR_W'(n2) +
                   ADDR_W'(p23) + ADDR_W'(n3);

    assign last_word = (addr == total - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n0         <= '0;
            n1         <= '0;
            n2         <= '0;
            n3         <= '0;
            t          <= '0;
            phase      <= 1'b0;
            j          <= '0;
            i          <= '0;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_layer   <= '0;
            wr_is_bias <= 1'b0;
            wr_neuron  <= '0;
            wr_input   <= '0;
            busy       <= 1'b0;
            loaded     <= 1'b0;
            err        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (load) begin
                n0      <= first_layer;
                n1      <= second_layer;
                n2      <= third_layer;
                n3      <= fourth_layer;
                t       <= '0;
                phase   <= 1'b0;
                j       <= '0;
                i       <= '0;
                addr    <= '0;
                loaded  <= 1'b0;
                overrun <= 1'b0;
                err     <= any_zero;
                busy    <= ~any_zero;
                state   <= any_zero ? ERR : RECV;
            end else begin
                case (state)
                    RECV: begin
                        if (in_valid) begin
                            wr_en      <= 1'b1;
                            wr_data    <= data;
                            wr_addr    <= addr;
                            wr_layer   <= t;
                            wr_is_bias <= phase;
                            wr_neuron  <= j;
                            wr_input   <= phase ? '0 : i;
                            addr       <= addr + ADDR_W'(1);
                            if (!phase) begin
                                if (i == n_in - SIZE_W'(1)) begin
                                    i <= '0;
                                    if (j == n_out - SIZE_W'(1)) begin
                                        j     <= '0;
                                        phase <= 1'b1;
                                    end else begin
                                        j <= j + SIZE_W'(1);
                                    end
                                end else begin
                                    i <= i + SIZE_W'(1);
                                end
                            end else begin
                                if (j == n_out - SIZE_W'(1)) begin
                                    j     <= '0;
                                    phase <= 1'b0;
                                    t     <= t + 2'd1;
                                end else begin
                                    j <= j + SIZE_W'(1);
                                end
                            end
                            if (last_word) begin
                                state  <= DONE;
                                loaded <= 1'b1;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        if (in_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ff_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_param_loader
// Description : Scoreboard bench for ff_param_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [3:0]  first_layer = '0, second_layer = '0, third_layer = '0, fourth_layer = '0;
    logic [31:0] data = '0;
    logic        in_valid = 1'b0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_layer;
    logic        wr_is_bias;
    logic [3:0]  wr_neuron;
    logic [3:0]  wr_input;
    logic        busy, loaded, err, overrun;

    ff_param_loader #(.DATA_W(32), .SIZE_W(4), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .load(load),
        .first_layer(first_layer), .second_layer(second_layer),
        .third_layer(third_layer), .fourth_layer(fourth_layer),
        .data(data), .in_valid(in_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_layer(wr_layer), .wr_is_bias(wr_is_bias),
        .wr_neuron(wr_neuron), .wr_input(wr_input),
        .busy(busy), .loaded(loaded), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [1:0]  layer;
        logic        bias;
        logic [3:0]  neuron;
        logic [3:0]  inp;
        logic        last;
        int          cyc;
    } item_t;

    item_t       plan[$];
    item_t       exp_q[$];
    int          plan_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [10:0] obs[0:1023];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write must match the oldest pending expectation
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            obs[wr_addr] = {wr_layer, wr_is_bias, wr_neuron, wr_input};
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {54'd0, wr_addr}, 64'h3FF);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                chk("wr_addr",   64'(wr_addr),    64'(e.addr));
                chk("wr_data",   64'(wr_data),    64'(e.data));
                chk("wr_layer",  64'(wr_layer),   64'(e.layer));
                chk("wr_bias",   64'(wr_is_bias), 64'(e.bias));
                chk("wr_neuron", 64'(wr_neuron),  64'(e.neuron));
                chk("wr_input",  64'(wr_input),   64'(e.inp));
                chk("loaded_at_wr", 64'(loaded),  64'(e.last));
                chk("latency",   64'(cyc),        64'(e.cyc));
            end
        end
    end

    task automatic build_plan(input int a, input int b, input int c, input int d);
        int    n[4];
        item_t e;
        int    k;
        n[0] = a; n[1] = b; n[2] = c; n[3] = d;
        plan.delete();
        plan_idx = 0;
        if (a == 0 || b == 0 || c == 0 || d == 0) return;
        k = 0;
        e.data = '0; e.cyc = 0; e.last = 1'b0;
        for (int t = 0; t < 3; t++) begin
            for (int jj = 0; jj < n[t+1]; jj++) begin
                for (int ii = 0; ii < n[t]; ii++) begin
                    e.addr = 10'(k); e.layer = 2'(t); e.bias = 1'b0;
                    e.neuron = 4'(jj); e.inp = 4'(ii);
                    plan.push_back(e); k++;
                end
            end
            for (int jj = 0; jj < n[t+1]; jj++) begin
                e.addr = 10'(k); e.layer = 2'(t); e.bias = 1'b1;
                e.neuron = 4'(jj); e.inp = 4'd0;
                plan.push_back(e); k++;
            end
        end
        plan[plan.size()-1].last = 1'b1;
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d);
        @(posedge clk); #1;
        first_layer = 4'(a); second_layer = 4'(b);
        third_layer = 4'(c); fourth_layer = 4'(d);
        load = 1'b1;
        in_valid = 1'b1;
        data = 32'hDEADBEEF;
        build_plan(a, b, c, d);
        @(posedge clk); #1;
        load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps, input bit idle_after);
        item_t e;
        for (int k = 0; k < n; k++) begin
            if (k != 0 || !gaps) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            data = 32'h3F800000 + 32'(k);
            if (plan_idx < plan.size()) begin
                e = plan[plan_idx];
                e.data = data;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
                plan_idx++;
            end
            if (gaps) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (idle_after) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {6'd0, wr_en, wr_addr, wr_data, wr_layer, wr_is_bias, wr_neuron,
                wr_input, busy, loaded, err, overrun};
    endfunction

    int chk_addr[6]  = '{0, 23, 24, 30, 65, 82};
    int chk_field[6] = '{ {2'd0,1'b0,4'd0,4'd0}, {2'd0,1'b0,4'd5,4'd3},
                          {2'd0,1'b1,4'd0,4'd0}, {2'd1,1'b0,4'd0,4'd0},
                          {2'd2,1'b0,4'd0,4'd0}, {2'd2,1'b1,4'd2,4'd0} };

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);

        // Full 4,6,5,3 stream, back-to-back
        wr_cnt = 0;
        do_load(4, 6, 5, 3);
        @(negedge clk);
        chk("busy_recv", 64'(busy), 64'd1);
        send(83, 1'b0, 1'b1);
        @(negedge clk);
        chk("s1_count", 64'(wr_cnt), 64'd83);
        chk("s1_loaded", 64'(loaded), 64'd1);
        chk("s1_busy", 64'(busy), 64'd0);
        chk("s1_err", 64'(err), 64'd0);
        chk("s1_overrun", 64'(overrun), 64'd0);
        chk("s1_drained", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 6; k++)
            chk("s1_index_table", 64'(obs[chk_addr[k]]), 64'(chk_field[k]));

        // Surplus words after completion
        wr_cnt = 0;
        do_load(4, 6, 5, 3);
        send(92, 1'b0, 1'b1);
        @(negedge clk);
        chk("s2_count", 64'(wr_cnt), 64'd83);
        chk("s2_overrun", 64'(overrun), 64'd1);
        chk("s2_loaded", 64'(loaded), 64'd1);
        chk("s2_drained", 64'(exp_q.size()), 64'd0);

        // Minimal sizes with alternating valid
        wr_cnt = 0;
        do_load(1, 1, 1, 1);
        chk("s3_overrun_cleared", 64'(overrun), 64'd0);
        send(8, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_count", 64'(wr_cnt), 64'd6);
        chk("s3_loaded", 64'(loaded), 64'd1);
        chk("s3_overrun", 64'(overrun), 64'd1);

        // Zero size -> ERR, then recover
        wr_cnt = 0;
        do_load(4, 0, 5, 3);
        @(negedge clk);
        chk("s4_err", 64'(err), 64'd1);
        chk("s4_busy", 64'(busy), 64'd0);
        chk("s4_loaded", 64'(loaded), 64'd0);
        send(10, 1'b0, 1'b1);
        @(negedge clk);
        chk("s4_no_writes", 64'(wr_cnt), 64'd0);
        chk("s4_err_sticky", 64'(err), 64'd1);
        do_load(2, 2, 2, 2);
        @(negedge clk);
        chk("s4_err_cleared", 64'(err), 64'd0);
        send(18, 1'b0, 1'b1);
        @(negedge clk);
        chk("s4_count", 64'(wr_cnt), 64'd18);
        chk("s4_loaded2", 64'(loaded), 64'd1);

        // Restart mid-stream
        wr_cnt = 0;
        do_load(4, 6, 5, 3);
        send(40, 1'b0, 1'b0);
        do_load(4, 6, 5, 3);
        @(negedge clk);
        chk("s5_loaded_mid", 64'(loaded), 64'd0);
        send(83, 1'b0, 1'b1);
        @(negedge clk);
        chk("s5_count", 64'(wr_cnt), 64'd123);
        chk("s5_loaded", 64'(loaded), 64'd1);
        chk("s5_drained", 64'(exp_q.size()), 64'd0);

        // Reset during RECV
        wr_cnt = 0;
        do_load(4, 6, 5, 3);
        send(10, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        plan.delete();
        plan_idx = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_rst_outputs", all_outs(), 64'd0);
        send(5, 1'b0, 1'b1);
        @(negedge clk);
        chk("s6_count", 64'(wr_cnt), 64'd10);
        chk("s6_idle_outputs", all_outs(), 64'd0);
        chk("s6_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
